// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, also used by baud_rate_generation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_BAUD       = 9600;
    localparam int UART_SYSCLK_HZ  = 100_000_000;
    localparam int UART_BAUD_DIV   = 651;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a 3-deep oversample register
// whose majority is the voted bit.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic sysclk,
    input  logic reset,
    input  logic baud_en,
    input  logic rxd,
    output logic rxd_sync,
    output logic rxd_vote
);

    logic       meta_q;
    logic       sync_q;
    logic [2:0] samp_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            samp_q <= 3'b111;
        end else begin
            meta_q <= rxd;
            sync_q <= meta_q;
            if (baud_en) begin
                samp_q <= {samp_q[1:0], sync_q};
            end
        end
    end

    assign rxd_sync = sync_q;
    assign rxd_vote = maj3(samp_q);

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling 8N1 UART receiver: start validation, mid-cell majority vote,
// one-cycle rx_valid / frame_err strobes.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | line idle, waiting for a low synchronised sample on baud_en
// ST_START | start bit seen, confirm it with the mid-cell vote
// ST_DATA  | collecting DATA_BITS votes, LSB first
// ST_STOP  | waiting for the stop-bit vote; strobe rx_valid or frame_err
// ST_BREAK | stop bit was 0, ignore the line until it returns high
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 baud_en,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW        = $clog2(OVERSAMPLE);
    localparam int IW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int VOTE_TICK = OVERSAMPLE / 2 + 1;

    rx_state_t            state_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 busy_q;
    logic                 rxd_sync;
    logic                 rxd_vote;
    logic                 vote_pt;

    uart_rx_sync u_sync (
        .sysclk   (sysclk),
        .reset    (reset),
        .baud_en  (baud_en),
        .rxd      (rxd),
        .rxd_sync (rxd_sync),
        .rxd_vote (rxd_vote)
    );

    always_comb begin
        cnt_d = (cnt_q == CW'(OVERSAMPLE - 1)) ? '0 : cnt_q + CW'(1);
    end

    // At this count the sample register holds the samples from ticks 7, 8 and 9 (16x).
    assign vote_pt = (cnt_q == CW'(VOTE_TICK));

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (baud_en) begin
                cnt_q <= cnt_d;
                unique case (state_q)
                    ST_IDLE: begin
                        if (!rxd_sync) begin
                            state_q <= ST_START;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (vote_pt) begin
                            if (rxd_vote) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_DATA;
                                idx_q   <= '0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (vote_pt) begin
                            shreg_q <= {rxd_vote, shreg_q[DATA_BITS-1:1]};
                            if (idx_q == IW'(DATA_BITS - 1)) begin
                                state_q <= ST_STOP;
                            end else begin
                                idx_q <= idx_q + IW'(1);
                            end
                        end
                    end
                    ST_STOP: begin
                        if (vote_pt) begin
                            busy_q <= 1'b0;
                            if (rxd_vote) begin
                                rx_data_q  <= shreg_q;
                                rx_valid_q <= 1'b1;
                                state_q    <= ST_IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_BREAK;
                            end
                        end
                    end
                    ST_BREAK: begin
                        if (rxd_sync) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed + randomized frames against a frame-level model of the receiver outputs.
module tb_uart_rx_oversample;

    localparam int BAUD_DIV = 8;
    localparam int TICK     = BAUD_DIV * 10;
    localparam int BT       = TICK * 16;
    localparam int BT_SLOW  = 1320;
    localparam int BT_FAST  = 1243;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       baud_en = 1'b0;
    logic       rxd    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_q[$];
    longint     rx_t[$];
    int         ferr_cnt = 0;
    int         both_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         exp_ferr  = 0;

    longint     t0;
    longint     dt;
    int         bt;
    int         gap;
    logic [7:0] d;
    logic       stop;

    uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .baud_en   (baud_en),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        forever begin
            repeat (BAUD_DIV - 1) @(negedge sysclk);
            baud_en = 1'b1;
            @(negedge sysclk);
            baud_en = 1'b0;
        end
    end

    always @(negedge sysclk) begin
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            rx_t.push_back($time);
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (rx_valid && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a good stop bit delivers the byte, a low stop bit only flags an error.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int bit_t);
        rxd = 1'b0;
        #bit_t;
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            #bit_t;
        end
        rxd = stop_bit;
        #bit_t;
        rxd = 1'b1;
        if (stop_bit) begin
            exp_q.push_back(data);
            last_good = data;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_data"}, rx_q.pop_front(), exp_q.pop_front());
        end
        rx_q.delete();
        exp_q.delete();
        rx_t.delete();
        check({tag, "_rx_data"}, rx_data, last_good);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
        check({tag, "_overlap"}, both_cnt, 0);
    endtask

    initial begin
        repeat (4) @(negedge sysclk);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        #(2 * BT);

        // single frame, latency about 9.5 cells after the start edge
        #($urandom_range(0, TICK - 1));
        t0 = $time;
        send_frame(8'hE9, 1'b1, BT);
        #(BT / 2);
        dt = (rx_t.size() > 0) ? rx_t[0] - t0 : 0;
        check("single_latency", (dt > BT * 19 / 2 - 5 * TICK) && (dt < BT * 19 / 2 + 5 * TICK), 1);
        check_rx("single");

        // back-to-back, no idle gap
        for (int i = 0; i < 3; i++) send_frame(8'hE9, 1'b1, BT);
        #(BT / 2);
        dt = (rx_t.size() == 3) ? rx_t[1] - rx_t[0] : 0;
        check("b2b_spacing1", (dt > 10 * BT - 2 * TICK) && (dt < 10 * BT + 2 * TICK), 1);
        dt = (rx_t.size() == 3) ? rx_t[2] - rx_t[1] : 0;
        check("b2b_spacing2", (dt > 10 * BT - 2 * TICK) && (dt < 10 * BT + 2 * TICK), 1);
        check_rx("b2b");

        // glitch shorter than the vote window
        @(negedge sysclk);
        #3;
        rxd = 1'b0;
        #(3 * TICK);
        rxd = 1'b1;
        #(3 * TICK);
        check("glitch_busy_high", busy, 1);
        #(12 * TICK);
        check("glitch_busy_low", busy, 0);
        check_rx("glitch");

        // framing error followed by a long break
        #($urandom_range(0, TICK - 1));
        send_frame(8'h55, 1'b0, BT);
        rxd = 1'b0;
        #(10 * BT);
        check("break_rx_data", rx_data, last_good);
        check("break_no_valid", rx_q.size(), 0);
        check("break_ferr", ferr_cnt, exp_ferr);
        #(10 * BT);
        rxd = 1'b1;
        #BT;
        send_frame(8'hA3, 1'b1, BT);
        #(BT / 2);
        check_rx("after_break");

        // reset during data bit 4
        d = 8'($urandom);
        rxd = 1'b0;
        #BT;
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            #BT;
        end
        rxd = d[4];
        #(BT / 2);
        @(negedge sysclk);
        reset = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge sysclk);
        check("midreset_rx_data", rx_data, 0);
        check("midreset_rx_valid", rx_valid, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_busy", busy, 0);
        last_good = 8'h00;
        reset = 1'b0;
        #(2 * BT);
        check_rx("aborted");
        send_frame(8'h3C, 1'b1, BT);
        #(BT / 2);
        check_rx("after_reset");

        // baud mismatch of about -3 % and +3 %
        send_frame(8'hE9, 1'b1, BT_SLOW);
        #(BT / 2);
        send_frame(8'hE9, 1'b1, BT_FAST);
        #(BT / 2);
        check_rx("tolerance");

        // randomized frames, rates and gaps
        for (int n = 0; n < 8; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       bt = BT_FAST;
                1:       bt = BT_SLOW;
                default: bt = BT;
            endcase
            send_frame(d, stop, bt);
            gap = $urandom_range(0, BT);
            if (!stop || bt == BT_FAST) gap += BT / 2;
            #gap;
        end
        #BT;
        check_rx("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
